// File: rtl/display_mode_ctrl_pkg.sv
// Shared constants and types for the display mode controller: screen
// encodings, VGA frame geometry, timeouts and the prompt-line window.
package display_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_TITLE = 2'd0,
    MODE_PLAY  = 2'd1,
    MODE_WIN   = 2'd2
  } mode_e;

  // Last scan position of an 800x525 frame.
  localparam logic [9:0] H_LAST = 10'd799;
  localparam logic [9:0] V_LAST = 10'd524;

  // Frames spent on the WIN screen before falling back to TITLE.
  localparam logic [8:0] WIN_TIMEOUT = 9'd300;

  // Blink half-period in frames; must be a power of two.
  localparam int BLINK_FRAMES = 32;
  localparam int BLINK_W      = $clog2(BLINK_FRAMES);

  // Rows of the "press start" prompt on the title screen.
  localparam logic [9:0] PROMPT_Y0 = 10'd400;
  localparam logic [9:0] PROMPT_Y1 = 10'd415;

  localparam logic [7:0] RGB_BLACK = 8'h00;

  // True when a scan line belongs to the blinking prompt.
  function automatic logic in_prompt(input logic [9:0] y);
    return (y >= PROMPT_Y0) && (y <= PROMPT_Y1);
  endfunction

endpackage

// File: rtl/display_mode_ctrl_if.sv
// Pixel-stream bundle between the VGA sync/layer logic and the mode
// controller.
//
// There is no valid/ready pair on this bus: pixel_tick is the only
// qualifier. A beat exists on each clk where pixel_tick=1; pixel_x,
// pixel_y, video_on and the layer colours are sampled on that edge and
// the colour for that beat appears on rgb_out right after it, holding
// until the next beat. The consumer can never stall the producer.
interface display_mode_ctrl_if;
  logic       pixel_tick;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [7:0] rgb_title;
  logic [7:0] rgb_maze;
  logic [7:0] rgb_win;
  logic [7:0] rgb_out;

  // Sync unit / layer side: produces the beat, receives the colour.
  modport master (
    output pixel_tick, video_on, pixel_x, pixel_y,
    output rgb_title, rgb_maze, rgb_win,
    input  rgb_out
  );

  // Mode controller side.
  modport slave (
    input  pixel_tick, video_on, pixel_x, pixel_y,
    input  rgb_title, rgb_maze, rgb_win,
    output rgb_out
  );
endinterface

// File: rtl/display_mode_ctrl_frame_timer.sv
// Frame timing: detects the last pixel of each frame, emits a one-clk
// frame_tick after it, counts frames since the last screen change
// (saturating) and derives the slow blink square wave.
module display_mode_ctrl_frame_timer
  import display_mode_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,       // synchronous, active low
  input  logic       pixel_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       clr_frames,  // screen is changing this clk
  output logic       frame_end,   // combinational: last pixel beat now
  output logic       frame_tick,
  output logic [8:0] frame_cnt,
  output logic       blink
);

  logic               frame_tick_q, frame_tick_d;
  logic [8:0]         frame_cnt_q, frame_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;

  // Frame-end detect and next values of the frame and blink counters.
  always_comb begin
    frame_end    = pixel_tick && (pixel_x == H_LAST) && (pixel_y == V_LAST);
    frame_tick_d = frame_end;

    frame_cnt_d = frame_cnt_q;
    if (clr_frames) begin
      frame_cnt_d = '0;
    end else if (frame_end && (frame_cnt_q < WIN_TIMEOUT)) begin
      frame_cnt_d = frame_cnt_q + 9'd1;
    end

    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (frame_end) begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_d = ~blink_q;
      end
    end
  end

  // Timer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
      blink_cnt_q  <= '0;
      blink_q      <= 1'b0;
    end else begin
      frame_tick_q <= frame_tick_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_q      <= blink_d;
    end
  end

  assign frame_tick = frame_tick_q;
  assign frame_cnt  = frame_cnt_q;
  assign blink      = blink_q;

endmodule

// File: rtl/display_mode_ctrl.sv
// Screen sequencer for the maze game: TITLE -> PLAY -> WIN -> TITLE.
// Button and goal events are latched and only acted on at frame end so
// a screen never changes mid-frame. Also selects the visible layer and
// registers the pixel colour once per pixel beat.
module display_mode_ctrl
  import display_mode_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,      // synchronous, active low
  display_mode_ctrl_if.slave   vid,
  input  logic                 start_btn,
  input  logic                 maze_done,
  output logic [1:0]           mode,
  output logic                 maze_en,
  output logic                 frame_tick,
  output logic                 blink
);

  logic       frame_end;
  logic [8:0] frame_cnt;
  logic       mode_chg;
  logic       start_evt;

  mode_e      mode_q, mode_d;
  logic       start_prev_q, start_prev_d;
  logic       start_pend_q, start_pend_d;
  logic       maze_pend_q, maze_pend_d;
  logic       maze_en_q, maze_en_d;
  logic [7:0] rgb_q, rgb_d;

  display_mode_ctrl_frame_timer frame_timer (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (vid.pixel_tick),
    .pixel_x    (vid.pixel_x),
    .pixel_y    (vid.pixel_y),
    .clr_frames (mode_chg),
    .frame_end  (frame_end),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt),
    .blink      (blink)
  );

  // Event capture and screen sequencing. Pending flags are consumed at
  // every frame end; an event landing on the frame-end clk itself is
  // kept for the following frame end.
  always_comb begin
    start_evt    = start_btn && !start_prev_q;
    start_prev_d = start_btn;
    start_pend_d = frame_end ? start_evt : (start_pend_q || start_evt);
    maze_pend_d  = frame_end ? maze_done : (maze_pend_q || maze_done);

    mode_d = mode_q;
    case (mode_q)
      MODE_TITLE: if (frame_end && start_pend_q) mode_d = MODE_PLAY;
      // Goal beats a simultaneous start; start alone is ignored here.
      MODE_PLAY:  if (frame_end && maze_pend_q) mode_d = MODE_WIN;
      // Leave on start, or on the frame end that completes the timeout.
      MODE_WIN:   if (frame_end && (start_pend_q ||
                                    (frame_cnt >= WIN_TIMEOUT - 9'd1)))
                    mode_d = MODE_TITLE;
      default:    mode_d = MODE_TITLE;
    endcase

    mode_chg  = (mode_d != mode_q);
    maze_en_d = (mode_d == MODE_PLAY);
  end

  // Pixel colour select, evaluated only on a pixel beat.
  always_comb begin
    rgb_d = rgb_q;
    if (vid.pixel_tick) begin
      if (!vid.video_on) begin
        rgb_d = RGB_BLACK;
      end else begin
        case (mode_q)
          MODE_TITLE: rgb_d = (!blink && in_prompt(vid.pixel_y)) ? RGB_BLACK
                                                                 : vid.rgb_title;
          MODE_PLAY:  rgb_d = vid.rgb_maze;
          MODE_WIN:   rgb_d = vid.rgb_win;
          default:    rgb_d = RGB_BLACK;
        endcase
      end
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q       <= MODE_TITLE;
      start_prev_q <= 1'b0;
      start_pend_q <= 1'b0;
      maze_pend_q  <= 1'b0;
      maze_en_q    <= 1'b0;
      rgb_q        <= RGB_BLACK;
    end else begin
      mode_q       <= mode_d;
      start_prev_q <= start_prev_d;
      start_pend_q <= start_pend_d;
      maze_pend_q  <= maze_pend_d;
      maze_en_q    <= maze_en_d;
      rgb_q        <= rgb_d;
    end
  end

  assign mode        = mode_q;
  assign maze_en     = maze_en_q;
  assign vid.rgb_out = rgb_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Directed bench for display_mode_ctrl. The driver pushes expected
// colours and expected per-frame state into queues; the monitor pops
// and compares when the DUT shows a colour beat or a frame_tick.
module tb_display_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_btn = 1'b0;
  logic       maze_done = 1'b0;
  logic [1:0] mode;
  logic       maze_en;
  logic       frame_tick;
  logic       blink;

  display_mode_ctrl_if vid();

  display_mode_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .vid        (vid.slave),
    .start_btn  (start_btn),
    .maze_done  (maze_done),
    .mode       (mode),
    .maze_en    (maze_en),
    .frame_tick (frame_tick),
    .blink      (blink)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] rgb_exp_q[$];
  logic [3:0] fe_exp_q[$];   // {blink, maze_en, mode}
  logic       rgb_chk = 1'b0;
  logic       chk_seen = 1'b0;
  int         fe_count = 0;  // frame ends since last reset

  always @(posedge clk) chk_seen <= rgb_chk;

  task automatic check8(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (chk_seen) begin
      if (rgb_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rgb_extra: got 0x%02h expected no beat", vid.rgb_out);
      end else begin
        check8("rgb_out", vid.rgb_out, rgb_exp_q.pop_front());
      end
    end
    if (frame_tick) begin
      if (fe_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame_extra: got frame_tick=1 expected 0");
      end else begin
        check8("frame_state{blink,maze_en,mode}",
               {4'b0, blink, maze_en, mode}, {4'b0, fe_exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y,
                     input logic von, input logic chk, input logic [7:0] exp);
    vid.pixel_x    = x;
    vid.pixel_y    = y;
    vid.video_on   = von;
    vid.pixel_tick = 1'b1;
    rgb_chk        = chk;
    if (chk) rgb_exp_q.push_back(exp);
    step();
    vid.pixel_tick = 1'b0;
    rgb_chk        = 1'b0;
  endtask

  task automatic hold_chk(input logic [7:0] exp);
    vid.pixel_tick = 1'b0;
    rgb_chk        = 1'b1;
    rgb_exp_q.push_back(exp);
    step();
    rgb_chk = 1'b0;
  endtask

  task automatic frame_end(input logic [1:0] exp_mode);
    logic exp_blink;
    fe_count++;
    exp_blink = ((fe_count / 32) % 2) == 1;
    fe_exp_q.push_back({exp_blink, exp_mode == 2'd1, exp_mode});
    vid.pixel_x    = 10'd799;
    vid.pixel_y    = 10'd524;
    vid.video_on   = 1'b0;
    vid.pixel_tick = 1'b1;
    step();
    vid.pixel_tick = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    start_btn = 1'b1; step();
    start_btn = 1'b0; step();
  endtask

  task automatic pulse_maze();
    maze_done = 1'b1; step();
    maze_done = 1'b0; step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vid.pixel_tick = 1'b0;
    vid.video_on   = 1'b0;
    vid.pixel_x    = '0;
    vid.pixel_y    = '0;
    vid.rgb_title  = 8'hE0;
    vid.rgb_maze   = 8'h1C;
    vid.rgb_win    = 8'h03;

    // Reset state.
    reset = 1'b0;
    repeat (3) step();
    check8("rst_mode", {6'b0, mode}, 8'h00);
    check8("rst_rgb", vid.rgb_out, 8'h00);
    check8("rst_maze_en", {7'b0, maze_en}, 8'h00);
    check8("rst_frame_tick", {7'b0, frame_tick}, 8'h00);
    check8("rst_blink", {7'b0, blink}, 8'h00);
    reset = 1'b1;
    step();

    // Title screen, blink=0: prompt rows blanked, edges included.
    vid.rgb_title = 8'hFF;
    pix(10, 405, 1'b1, 1'b1, 8'h00);
    pix(10, 200, 1'b1, 1'b1, 8'hFF);
    pix(10, 400, 1'b1, 1'b1, 8'h00);
    pix(10, 415, 1'b1, 1'b1, 8'h00);
    pix(10, 399, 1'b1, 1'b1, 8'hFF);
    pix(10, 416, 1'b1, 1'b1, 8'hFF);
    hold_chk(8'hFF);
    hold_chk(8'hFF);
    pix(10, 200, 1'b0, 1'b1, 8'h00);

    // maze_done ignored on the title screen; 32 frames turn blink on.
    pulse_maze();
    repeat (32) frame_end(2'd0);
    pix(10, 405, 1'b1, 1'b1, 8'hFF);
    pix(10, 200, 1'b1, 1'b1, 8'hFF);
    pix(10, 405, 1'b0, 1'b1, 8'h00);

    // Start pulse mid-frame: mode waits for frame end.
    pix(100, 100, 1'b1, 1'b1, 8'hFF);
    pulse_start();
    pix(200, 100, 1'b1, 1'b0, 8'h00);
    check8("mode_mid_frame", {6'b0, mode}, 8'h00);
    check8("maze_en_mid_frame", {7'b0, maze_en}, 8'h00);
    frame_end(2'd1);
    pix(100, 100, 1'b1, 1'b1, 8'h1C);
    hold_chk(8'h1C);

    // Start alone ignored in PLAY; start plus goal in one frame -> WIN.
    pulse_start();
    frame_end(2'd1);
    pulse_start();
    pulse_maze();
    frame_end(2'd2);
    pix(50, 50, 1'b1, 1'b1, 8'h03);

    // Start arriving on the frame-end clk applies one frame later.
    start_btn = 1'b1;
    frame_end(2'd2);
    start_btn = 1'b0;
    frame_end(2'd0);
    pix(50, 50, 1'b1, 1'b1, 8'hFF);

    // Held start from WIN: one transition to TITLE only.
    pulse_start();
    frame_end(2'd1);
    pulse_maze();
    frame_end(2'd2);
    start_btn = 1'b1;
    step();
    frame_end(2'd0);
    frame_end(2'd0);
    frame_end(2'd0);
    start_btn = 1'b0;
    step();
    frame_end(2'd0);

    // WIN timeout: still WIN after 299 frames, TITLE at the 300th.
    pulse_start();
    frame_end(2'd1);
    pulse_maze();
    frame_end(2'd2);
    for (int i = 1; i <= 300; i++) frame_end((i == 300) ? 2'd0 : 2'd2);
    frame_end(2'd0);

    // Into PLAY, run a few frames so the blink counter is mid-count.
    pulse_start();
    frame_end(2'd1);
    repeat (10) frame_end(2'd1);
    pix(20, 20, 1'b1, 1'b1, 8'h1C);

    // Reset mid-frame in PLAY with start held high across release.
    start_btn      = 1'b1;
    reset          = 1'b0;
    vid.pixel_x    = 10'd30;
    vid.pixel_y    = 10'd30;
    vid.video_on   = 1'b1;
    vid.pixel_tick = 1'b1;
    step();
    vid.pixel_tick = 1'b0;
    fe_count = 0;
    check8("midplay_rst_mode", {6'b0, mode}, 8'h00);
    check8("midplay_rst_rgb", vid.rgb_out, 8'h00);
    check8("midplay_rst_maze_en", {7'b0, maze_en}, 8'h00);
    check8("midplay_rst_blink", {7'b0, blink}, 8'h00);
    reset = 1'b1;
    step();

    // Held-high start is still seen as the first edge after reset; the
    // blink counter restarts from zero.
    frame_end(2'd1);
    start_btn = 1'b0;
    repeat (31) frame_end(2'd1);

    repeat (4) step();
    checks++;
    if (rgb_exp_q.size() != 0) begin
      errors++;
      $display("FAIL rgb_queue_left: got %0d expected 0", rgb_exp_q.size());
    end
    checks++;
    if (fe_exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_queue_left: got %0d expected 0", fe_exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_mode_ctrl.md
DISPLAY_MODE_CTRL -- requirements
Module: display_mode_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole system clock, all logic on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset), sampled on clk.
REQ-003 SHALL have port pixel_tick  input  1  one-clk pixel-rate enable from the VGA sync unit.
REQ-004 SHALL have port video_on  input  1  high inside the 640x480 visible area.
REQ-005 SHALL have ports pixel_x, pixel_y  input  10 each  current scan position (800x525 frame).
REQ-006 SHALL have port start_btn  input  1  debounced, clk-synchronous start button level.
REQ-007 SHALL have port maze_done  input  1  one-clk pulse from the maze logic: goal reached.
REQ-008 SHALL have ports rgb_title, rgb_maze, rgb_win  input  8 each  layer colours, RRRGGGBB.
REQ-009 SHALL have port rgb_out  output  8  registered pixel colour to the VGA pins.
REQ-010 SHALL have port mode  output  2  current screen: 0 TITLE, 1 PLAY, 2 WIN.
REQ-011 SHALL have port maze_en  output  1  high only while mode = PLAY.
REQ-012 SHALL have port frame_tick  output  1  one-clk pulse at each frame end.
REQ-013 SHALL have port blink  output  1  slow square wave for text blinking.

Function
REQ-014 Frame end SHALL be pixel_tick=1 with pixel_x=799 and pixel_y=524; frame_tick SHALL pulse in the following cycle.
REQ-015 start_btn SHALL be rising-edge detected (previous-level register); a level held high SHALL produce one event only.
REQ-016 Events SHALL be latched into a pending register; mode changes SHALL take effect only at frame end, then clear pending.
REQ-017 Transitions: TITLE + start event -> PLAY; PLAY + maze_done -> WIN; WIN + start event -> TITLE; WIN + 300 frames elapsed -> TITLE.
REQ-018 In PLAY, start events SHALL be ignored; in TITLE and WIN, maze_done SHALL be ignored.
REQ-019 If start and maze_done both pend in PLAY at frame end, maze_done SHALL win (-> WIN).
REQ-020 An event arriving in the same cycle as frame end SHALL be latched and applied at the next frame end.
REQ-021 An unused mode encoding (3) SHALL return to TITLE at the next clk.
REQ-022 Frame counter: 9 bits, cleared on every mode change, increments on each frame end, saturates at 300.
REQ-023 blink SHALL toggle every 32 frame ends (free-running 5-bit counter), independent of mode.
REQ-024 rgb_out SHALL update only on pixel_tick, latency exactly one pixel_tick: video_on=0 -> 0x00; else TITLE -> rgb_title, PLAY -> rgb_maze, WIN -> rgb_win.
REQ-025 In TITLE with blink=0, pixels with 400 <= pixel_y <= 415 SHALL output 0x00 (prompt line blanked).
REQ-026 Between pixel_ticks, rgb_out SHALL hold its value.

Reset
REQ-027 With reset=0 at a clk edge: mode=TITLE, rgb_out=0x00, maze_en=0, frame_tick=0, blink=0, all counters, pending flags and edge register =0.
REQ-028 Reset mid-frame or mid-PLAY SHALL abort immediately, without waiting for frame end.
REQ-029 The first start_btn rising edge after reset release SHALL be detected even if start_btn was high during reset: edge register reset to 0.

Structure
REQ-030 A shared package SHALL hold the mode encodings, H_LAST=799, V_LAST=524, WIN_TIMEOUT=300, BLINK_FRAMES=32, PROMPT_Y0=400, PROMPT_Y1=415.
REQ-031 Frame detection, frame counter and blink counter SHALL form one sub-module, frame_timer; the FSM and pixel mux stay in display_mode_ctrl.

Verification
REQ-032 Reset, then a start pulse mid-frame -> mode stays 0 until frame end, becomes 1 the cycle after, maze_en=1, rgb_out follows rgb_maze=0x1C one pixel_tick later.
REQ-033 PLAY, start and maze_done in the same frame -> mode=2 at frame end; start has no effect.
REQ-034 WIN, no input for 300 frames -> mode=0 at the 300th frame end; at 299 frames still 2.
REQ-035 TITLE, rgb_title=0xFF, pixel_y=405, blink=0 -> rgb_out=0x00; blink=1 -> 0xFF; pixel_y=200 -> 0xFF either way; video_on=0 -> 0x00.
REQ-036 start_btn held high 3 frames from WIN -> single transition to TITLE only, no further change to PLAY.
REQ-037 reset=0 asserted during PLAY mid-frame -> next clk mode=0, rgb_out=0x00, counters 0.
